// File: rtl/trigger_pulse_pkg.sv
// trigger_pulse_pkg: FSM state encoding, default timing values and a counter
// sizing helper shared by trigger_pulse_capture.
package trigger_pulse_pkg;

    typedef enum logic [1:0] {
        ST_INIT     = 2'd0,
        ST_ARMED    = 2'd1,
        ST_CLEARING = 2'd2,
        ST_HOLDOFF  = 2'd3
    } tpc_state_e;

    localparam int DEFAULT_SYNC_STAGES = 2;
    localparam int DEFAULT_CLR_WIDTH   = 2;
    localparam int DEFAULT_HOLDOFF     = 8;
    localparam int DEFAULT_CNT_WIDTH   = 16;

    // Bits needed to hold any value in 0..max_val, never fewer than one.
    function automatic int cnt_bits(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/sync_ff.sv
// sync_ff: N-stage single-bit synchronizer; every stage resets to 0.
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/trigger_pulse_capture.sv
// trigger_pulse_capture: synchronizes the P/N trigger latch flags, issues a
// one-cycle strobe, pulses the latch clears and enforces holdoff before re-arm.
module trigger_pulse_capture
    import trigger_pulse_pkg::*;
#(
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES,
    parameter int CLR_WIDTH   = DEFAULT_CLR_WIDTH,
    parameter int HOLDOFF     = DEFAULT_HOLDOFF,
    parameter int CNT_WIDTH   = DEFAULT_CNT_WIDTH
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 TRIG_P,
    input  logic                 TRIG_N,
    input  logic                 ENABLE,
    input  logic                 ERR_CLR,
    output logic                 TRIG_OUT,
    output logic                 CLR_P,
    output logic                 CLR_N,
    output logic                 ARMED,
    output logic [CNT_WIDTH-1:0] TRIG_COUNT,
    output logic                 STUCK_ERR
);

    localparam int CLR_CNT_W  = cnt_bits(CLR_WIDTH);
    localparam int HOLD_CNT_W = cnt_bits(HOLDOFF);
    localparam int WAIT_CNT_W = cnt_bits(SYNC_STAGES + 1);

    logic s_p;
    logic s_n;
    logic any_flag;

    tpc_state_e state_q, state_d;
    logic [CLR_CNT_W-1:0]  clr_cnt_q, clr_cnt_d;
    logic [HOLD_CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [CNT_WIDTH-1:0]  trig_count_q, trig_count_d;
    logic                  trig_out_q, trig_out_d;
    logic                  clr_q, clr_d;
    logic                  armed_q, armed_d;
    logic                  stuck_q, stuck_d;
    logic                  stuck_set;

    sync_ff #(.STAGES(SYNC_STAGES)) u_sync_p (
        .clk   (CLK),
        .rst_n (RST_N),
        .d     (TRIG_P),
        .q     (s_p)
    );

    sync_ff #(.STAGES(SYNC_STAGES)) u_sync_n (
        .clk   (CLK),
        .rst_n (RST_N),
        .d     (TRIG_N),
        .q     (s_n)
    );

    assign any_flag = s_p | s_n;

    always_comb begin
        state_d      = state_q;
        clr_cnt_d    = clr_cnt_q;
        hold_cnt_d   = hold_cnt_q;
        wait_cnt_d   = wait_cnt_q;
        trig_count_d = trig_count_q;
        trig_out_d   = 1'b0;
        clr_d        = 1'b0;
        stuck_set    = 1'b0;

        case (state_q)
            ST_INIT: begin
                state_d   = ST_CLEARING;
                clr_cnt_d = CLR_CNT_W'(CLR_WIDTH);
                clr_d     = 1'b1;
            end
            ST_ARMED: begin
                if (any_flag) begin
                    state_d   = ST_CLEARING;
                    clr_cnt_d = CLR_CNT_W'(CLR_WIDTH);
                    clr_d     = 1'b1;
                    if (ENABLE) begin
                        trig_out_d   = 1'b1;
                        trig_count_d = trig_count_q + CNT_WIDTH'(1);
                    end
                end
            end
            // clr_cnt holds the clear cycles still owed, including the current one.
            ST_CLEARING: begin
                if (clr_cnt_q == CLR_CNT_W'(1)) begin
                    state_d    = ST_HOLDOFF;
                    hold_cnt_d = HOLD_CNT_W'(HOLDOFF - 1);
                    wait_cnt_d = '0;
                end else begin
                    clr_cnt_d = clr_cnt_q - CLR_CNT_W'(1);
                    clr_d     = 1'b1;
                end
            end
            // After the holdoff expires, a flag may linger only as long as the
            // synchronizer needs to flush; beyond that the latch is stuck.
            ST_HOLDOFF: begin
                if (hold_cnt_q != '0) begin
                    hold_cnt_d = hold_cnt_q - HOLD_CNT_W'(1);
                end else if (!any_flag) begin
                    state_d = ST_ARMED;
                end else if (wait_cnt_q == WAIT_CNT_W'(SYNC_STAGES + 1)) begin
                    stuck_set = 1'b1;
                    state_d   = ST_CLEARING;
                    clr_cnt_d = CLR_CNT_W'(CLR_WIDTH);
                    clr_d     = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_INIT;
                clr_d   = 1'b1;
            end
        endcase

        if (stuck_set) begin
            stuck_d = 1'b1;
        end else if (ERR_CLR) begin
            stuck_d = 1'b0;
        end else begin
            stuck_d = stuck_q;
        end

        armed_d = (state_d == ST_ARMED);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q      <= ST_INIT;
            clr_cnt_q    <= CLR_CNT_W'(CLR_WIDTH);
            hold_cnt_q   <= '0;
            wait_cnt_q   <= '0;
            trig_count_q <= '0;
            trig_out_q   <= 1'b0;
            clr_q        <= 1'b1;
            armed_q      <= 1'b0;
            stuck_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            clr_cnt_q    <= clr_cnt_d;
            hold_cnt_q   <= hold_cnt_d;
            wait_cnt_q   <= wait_cnt_d;
            trig_count_q <= trig_count_d;
            trig_out_q   <= trig_out_d;
            clr_q        <= clr_d;
            armed_q      <= armed_d;
            stuck_q      <= stuck_d;
        end
    end

    assign TRIG_OUT   = trig_out_q;
    assign CLR_P      = clr_q;
    assign CLR_N      = clr_q;
    assign ARMED      = armed_q;
    assign TRIG_COUNT = trig_count_q;
    assign STUCK_ERR  = stuck_q;

endmodule

// File: tb/tb_trigger_pulse_capture.sv
// tb_trigger_pulse_capture: drives modelled P/N trigger latches into the DUT and
// predicts every output from trigger/clear/holdoff timestamps.
module tb_trigger_pulse_capture;

    localparam int SYNC        = 2;
    localparam int CW          = 2;
    localparam int HO          = 8;
    localparam int CNT_W       = 4;
    localparam int MIN_SPACING = 1 + CW + HO + SYNC;
    localparam int HIST_LEN    = 8192;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             trig_p;
    logic             trig_n;
    logic             enable;
    logic             err_clr;
    logic             trig_out;
    logic             clr_p;
    logic             clr_n;
    logic             armed;
    logic [CNT_W-1:0] trig_count;
    logic             stuck_err;

    int total = 0;
    int bad   = 0;
    int cyc;
    int last_strobe;

    bit hist_p [0:HIST_LEN-1];
    bit hist_n [0:HIST_LEN-1];
    bit req_p;
    bit req_n;
    bit fault_n;

    bit m_armed;
    bit m_trig;
    bit m_clr;
    bit m_stuck;
    int m_accepted;
    int clr_start;
    int decide_at;

    always #5 clk = ~clk;

    trigger_pulse_capture #(
        .SYNC_STAGES (SYNC),
        .CLR_WIDTH   (CW),
        .HOLDOFF     (HO),
        .CNT_WIDTH   (CNT_W)
    ) dut (
        .CLK        (clk),
        .RST_N      (rst_n),
        .TRIG_P     (trig_p),
        .TRIG_N     (trig_n),
        .ENABLE     (enable),
        .ERR_CLR    (err_clr),
        .TRIG_OUT   (trig_out),
        .CLR_P      (clr_p),
        .CLR_N      (clr_n),
        .ARMED      (armed),
        .TRIG_COUNT (trig_count),
        .STUCK_ERR  (stuck_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s at cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        cyc         = 0;
        last_strobe = -1;
        m_armed     = 1'b0;
        m_trig      = 1'b0;
        m_clr       = 1'b1;
        m_stuck     = 1'b0;
        m_accepted  = 0;
        clr_start   = 1;
        decide_at   = 1 + CW + HO;
    endtask

    // Flag value the DUT sees just before edge e: the latch level that was
    // present SYNC edges earlier.
    function automatic bit flag_seen(input int e);
        int idx;
        idx = e - SYNC - 1;
        if (idx < 0) return 1'b0;
        return hist_p[idx] | hist_n[idx];
    endfunction

    task automatic start_clear(input int e);
        clr_start = e;
        decide_at = e + CW + HO;
    endtask

    task automatic model_step(input int e);
        bit seen;
        bit stuck_new;
        seen      = flag_seen(e);
        stuck_new = 1'b0;
        m_trig    = 1'b0;
        if (m_armed) begin
            if (seen) begin
                m_armed = 1'b0;
                start_clear(e);
                if (enable) begin
                    m_trig = 1'b1;
                    m_accepted++;
                end
            end
        end else if (e >= decide_at) begin
            if (!seen) begin
                m_armed = 1'b1;
            end else if (e == decide_at + SYNC + 1) begin
                stuck_new = 1'b1;
                start_clear(e);
            end
        end
        if (stuck_new) m_stuck = 1'b1;
        else if (err_clr) m_stuck = 1'b0;
        m_clr = (e >= clr_start) && (e < clr_start + CW);
    endtask

    task automatic check_output();
        check("TRIG_OUT", 32'(trig_out), 32'(m_trig));
        check("CLR_P", 32'(clr_p), 32'(m_clr));
        check("CLR_N", 32'(clr_n), 32'(m_clr));
        check("ARMED", 32'(armed), 32'(m_armed));
        check("TRIG_COUNT", 32'(trig_count), 32'(m_accepted % (1 << CNT_W)));
        check("STUCK_ERR", 32'(stuck_err), 32'(m_stuck));
        if (trig_out === 1'b1) begin
            if (last_strobe >= 0)
                check("STROBE_SPACING", 32'(cyc - last_strobe >= MIN_SPACING), 32'd1);
            last_strobe = cyc;
        end
    endtask

    // One clock: latches respond at the falling edge, DUT sampled at the next one.
    task automatic apply_stimulus();
        if (clr_p === 1'b1) trig_p = 1'b0;
        if (clr_n === 1'b1 && !fault_n) trig_n = 1'b0;
        if (req_p && clr_p !== 1'b1) trig_p = 1'b1;
        if (req_n && clr_n !== 1'b1) trig_n = 1'b1;
        req_p = 1'b0;
        req_n = 1'b0;
        if (cyc < HIST_LEN) begin
            hist_p[cyc] = trig_p;
            hist_n[cyc] = trig_n;
        end
        @(posedge clk);
        cyc++;
        model_step(cyc);
        @(negedge clk);
        check_output();
    endtask

    task automatic run_until_armed(input int limit);
        for (int k = 0; k < limit && !m_armed; k++) apply_stimulus();
    endtask

    task automatic run_trigger_cycle();
        for (int k = 0; k < 2 * SYNC + 4 && m_armed; k++) apply_stimulus();
        run_until_armed(80);
    endtask

    task automatic fire(input bit p, input bit n);
        req_p = p;
        req_n = n;
        apply_stimulus();
    endtask

    initial begin
        int c;
        int sel;
        rst_n   = 1'b0;
        trig_p  = 1'b0;
        trig_n  = 1'b0;
        enable  = 1'b1;
        err_clr = 1'b0;
        req_p   = 1'b0;
        req_n   = 1'b0;
        fault_n = 1'b0;
        model_reset();

        repeat (3) @(negedge clk);
        check_output();
        rst_n = 1'b1;

        $display("[TB] startup");
        repeat (10) apply_stimulus();
        check("STARTUP_NOT_ARMED_10", 32'(armed), 32'd0);
        apply_stimulus();
        check("STARTUP_ARMED_11", 32'(armed), 32'd1);

        $display("[TB] single trigger");
        c = cyc;
        fire(1'b1, 1'b1);
        while (cyc < c + SYNC + 1) apply_stimulus();
        check("SINGLE_STROBE", 32'(trig_out), 32'd1);
        check("SINGLE_COUNT", 32'(trig_count), 32'd1);
        check("SINGLE_CLR_HIGH", 32'(clr_p & clr_n), 32'd1);
        apply_stimulus();
        check("SINGLE_STROBE_ONE_CYCLE", 32'(trig_out), 32'd0);
        apply_stimulus();
        check("SINGLE_CLR_WIDTH", 32'(clr_p | clr_n), 32'd0);
        run_until_armed(40);

        $display("[TB] disabled");
        enable = 1'b0;
        fire(1'b1, 1'b1);
        run_trigger_cycle();
        check("DISABLED_COUNT", 32'(trig_count), 32'd1);
        enable = 1'b1;

        $display("[TB] random triggers");
        for (int it = 0; it < 24; it++) begin
            repeat ($urandom_range(0, 3)) apply_stimulus();
            enable = ($urandom_range(0, 4) != 0);
            sel    = $urandom_range(1, 3);
            fire(sel[0], sel[1]);
            run_trigger_cycle();
        end
        enable = 1'b1;
        for (int it = 0; it < 24 && m_accepted < 17; it++) begin
            fire(1'b1, 1'b0);
            run_trigger_cycle();
        end

        $display("[TB] stuck latch");
        fault_n = 1'b1;
        c = cyc;
        fire(1'b1, 1'b1);
        while (cyc < c + SYNC + CW + HO + SYNC) apply_stimulus();
        err_clr = 1'b1;
        apply_stimulus();
        check("STUCK_NOT_YET", 32'(stuck_err), 32'd0);
        apply_stimulus();
        check("STUCK_SET_WINS", 32'(stuck_err), 32'd1);
        check("STUCK_RECLEAR", 32'(clr_p & clr_n), 32'd1);
        check("STUCK_NO_STROBE", 32'(trig_out), 32'd0);
        err_clr = 1'b0;
        fault_n = 1'b0;
        run_until_armed(60);
        check("STUCK_STICKY", 32'(stuck_err), 32'd1);
        err_clr = 1'b1;
        apply_stimulus();
        err_clr = 1'b0;
        check("ERR_CLR_CLEARS", 32'(stuck_err), 32'd0);

        $display("[TB] burst");
        for (int k = 0; k < 40; k++) fire(1'b1, 1'b1);
        run_until_armed(80);

        $display("[TB] reset mid-clear");
        fire(1'b0, 1'b1);
        for (int k = 0; k < 2 * SYNC + 4 && !m_trig; k++) apply_stimulus();
        rst_n = 1'b0;
        #1;
        check("RST_TRIG_OUT", 32'(trig_out), 32'd0);
        check("RST_CLR_P", 32'(clr_p), 32'd1);
        check("RST_CLR_N", 32'(clr_n), 32'd1);
        check("RST_ARMED", 32'(armed), 32'd0);
        check("RST_TRIG_COUNT", 32'(trig_count), 32'd0);
        check("RST_STUCK_ERR", 32'(stuck_err), 32'd0);
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_until_armed(40);
        check("REARM_AFTER_RESET", 32'(armed), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: run did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
